univ_shift_reg: RTL and testbench

//  Parametrised WIDTH-bit edge-triggered storage register: successor to the gated D latch cell.

---
 rtl/usr_pkg.sv | 18 +
 rtl/usr_frame_counter.sv | 57 +++++
 rtl/univ_shift_reg.sv | 127 ++++++++++++
 tb/tb_univ_shift_reg.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register slice.
//
// Contents:
//   MODE_*    two-bit operating mode encodings used on univ_shift_reg.mode
//   is_shift  helper returning 1 for the two shifting modes
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // True for the modes that move data and therefore advance the frame count.
    function automatic logic is_shift(input logic [1:0] mode_v);
        return (mode_v == MODE_SHL) || (mode_v == MODE_SHR);
    endfunction

endpackage

// File: rtl/usr_frame_counter.sv
// Frame counter for univ_shift_reg.
//
// Counts shift edges modulo WIDTH. When the WIDTH-th shift of a frame lands,
// the count wraps to zero and frame_done pulses high for exactly one cycle.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   step        in   1      a shift is applied on this edge
//   clear       in   1      a parallel load is applied on this edge (wins over step)
//   shift_cnt   out  CNT_W  shifts since last load/wrap, 0..WIDTH-1 (registered)
//   frame_done  out  1      one-cycle pulse after the WIDTH-th shift (registered)
module usr_frame_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             clear,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic             done_r;

    // Count register and completion pulse; any edge that is not a shift drops the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= CNT_ZERO;
            done_r <= 1'b0;
        end else if (clear) begin
            cnt_r  <= CNT_ZERO;
            done_r <= 1'b0;
        end else if (step) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r  <= CNT_ZERO;
                done_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + CNT_ONE;
                done_r <= 1'b0;
            end
        end else begin
            cnt_r  <= cnt_r;
            done_r <= 1'b0;
        end
    end

    assign shift_cnt  = cnt_r;
    assign frame_done = done_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with true/complement outputs and a
// frame counter. Modes: hold, shift-left, shift-right, parallel load.
//
// Build option: define USR_ROTATE_EN to add the rot port; with rot=1 the
// shifts recirculate the bit leaving the register instead of taking sin_r/sin_l.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   en          in   1      1 = apply mode this edge, 0 = hold (counter included)
//   mode        in   2      00 HOLD, 01 SHL, 10 SHR, 11 LOAD
//   sin_r       in   1      serial input entering bit 0 on SHL
//   sin_l       in   1      serial input entering bit WIDTH-1 on SHR
//   rot         in   1      (USR_ROTATE_EN only) 1 = shifts rotate
//   pdata       in   WIDTH  parallel load data
//   q           out  WIDTH  register contents
//   qbar        out  WIDTH  complement of q
//   sout_msb    out  1      q[WIDTH-1]
//   sout_lsb    out  1      q[0]
//   shift_cnt   out  CNT_W  shifts since last load/wrap
//   frame_done  out  1      one-cycle pulse on completion of WIDTH shifts
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         sin_r,
    input  logic                         sin_l,
`ifdef USR_ROTATE_EN
    input  logic                         rot,
`endif
    input  logic [WIDTH-1:0]             pdata,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             qbar,
    output logic                         sout_msb,
    output logic                         sout_lsb,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         frame_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             shl_fill_s;
    logic             shr_fill_s;
    logic             step_s;
    logic             clear_s;

    // Select the bit shifted into each end: serial inputs, or the outgoing bit when rotating.
    always_comb begin
        shl_fill_s = sin_r;
        shr_fill_s = sin_l;
`ifdef USR_ROTATE_EN
        if (rot) begin
            shl_fill_s = q_r[WIDTH-1];
            shr_fill_s = q_r[0];
        end else begin
            shl_fill_s = sin_r;
            shr_fill_s = sin_l;
        end
`endif
    end

    // Mode decode: next register value and the counter controls for this edge.
    always_comb begin
        q_next_s = q_r;
        step_s   = 1'b0;
        clear_s  = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_next_s = q_r;
                end
                MODE_SHL: begin
                    q_next_s = {q_r[WIDTH-2:0], shl_fill_s};
                end
                MODE_SHR: begin
                    q_next_s = {shr_fill_s, q_r[WIDTH-1:1]};
                end
                MODE_LOAD: begin
                    q_next_s = pdata;
                    clear_s  = 1'b1;
                end
                default: begin
                    q_next_s = q_r;
                end
            endcase
            step_s = is_shift(mode);
        end else begin
            q_next_s = q_r;
            step_s   = 1'b0;
            clear_s  = 1'b0;
        end
    end

    // Data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {WIDTH{1'b0}};
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q        = q_r;
    assign qbar     = ~q_r;
    assign sout_msb = q_r[WIDTH-1];
    assign sout_lsb = q_r[0];

    usr_frame_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step_s),
        .clear      (clear_s),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8). A stimulus process drives
// inputs on the falling edge and pushes the reference model's prediction; a
// monitor pops one prediction after every rising edge and compares.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic          sin_r;
    logic          sin_l;
    logic          rot;
    logic [W-1:0]  pdata;
    logic [W-1:0]  q;
    logic [W-1:0]  qbar;
    logic          sout_msb;
    logic          sout_lsb;
    logic [CW-1:0] shift_cnt;
    logic          frame_done;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
`ifdef USR_ROTATE_EN
        .rot        (rot),
`endif
        .pdata      (pdata),
        .q          (q),
        .qbar       (qbar),
        .sout_msb   (sout_msb),
        .sout_lsb   (sout_lsb),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    typedef struct {
        int q;
        int cnt;
        bit done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_q    = 0;   // model register value as an integer
    int   m_cnt  = 0;   // model shifts within current frame

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic view of one clock edge.
    task automatic model_step(input bit e, input int md, input int sr, input int sl,
                              input int pd, input bit rt);
        bit rt_eff;
        bit d;
        int full;
        int half;
        full   = 1 << W;
        half   = 1 << (W - 1);
        d      = 1'b0;
`ifdef USR_ROTATE_EN
        rt_eff = rt;
`else
        rt_eff = 1'b0;
`endif
        if (e) begin
            if (md == 1) begin
                m_q = ((m_q * 2) % full) + (rt_eff ? (m_q / half) : sr);
            end else if (md == 2) begin
                m_q = (m_q / 2) + (rt_eff ? (m_q % 2) : sl) * half;
            end else if (md == 3) begin
                m_q   = pd;
                m_cnt = 0;
            end
            if (md == 1 || md == 2) begin
                m_cnt++;
                if (m_cnt == W) begin
                    m_cnt = 0;
                    d     = 1'b1;
                end
            end
        end
        sb_q.push_back('{q: m_q, cnt: m_cnt, done: d});
    endtask

    task automatic drive(input bit e, input int md, input int sr, input int sl,
                         input int pd, input bit rt);
        @(negedge clk);
        en    = e;
        mode  = 2'(md);
        sin_r = 1'(sr);
        sin_l = 1'(sl);
        pdata = W'(pd);
        rot   = rt;
        model_step(e, md, sr, sl, pd, rt);
    endtask

    // Wait until the edge following the last drive has taken effect.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_q", q, 32'h0);
        chk("rst_qbar", qbar, 32'hFF);
        chk("rst_cnt", shift_cnt, 32'h0);
        chk("rst_done", frame_done, 32'h0);
        m_q   = 0;
        m_cnt = 0;
        en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every rising edge produces one state to check against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("q", q, e.q);
            chk("qbar", qbar, ~e.q & 32'hFF);
            chk("sout_msb", sout_msb, (e.q >> (W - 1)) & 1);
            chk("sout_lsb", sout_lsb, e.q & 1);
            chk("shift_cnt", shift_cnt, e.cnt);
            chk("frame_done", frame_done, e.done);
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        sin_r = 1'b0;
        sin_l = 1'b0;
        rot   = 1'b0;
        pdata = '0;
        #3;
        chk("init_q", q, 32'h0);
        chk("init_qbar", qbar, 32'hFF);
        chk("init_cnt", shift_cnt, 32'h0);
        chk("init_done", frame_done, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-frame with q=A5, shift_cnt=3.
        drive(1, 3, 0, 0, 8'h14, 0);
        drive(1, 1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        settle();
        chk("pre_rst_q", q, 32'hA5);
        chk("pre_rst_cnt", shift_cnt, 32'h3);
        async_reset();

        // LOAD 81 then eight SHL with sin_r=1.
        drive(1, 3, 0, 0, 8'h81, 0);
        for (int i = 0; i < W; i++) drive(1, 1, 1, 0, 0, 0);
        settle();
        chk("t2_q", q, 32'hFF);
        chk("t2_done", frame_done, 32'h1);
        chk("t2_cnt", shift_cnt, 32'h0);

        // LOAD F0 then four SHR with sin_l=0.
        drive(1, 3, 0, 0, 8'hF0, 0);
        for (int i = 0; i < 4; i++) drive(1, 2, 0, 0, 0, 0);
        settle();
        chk("t3_q", q, 32'h0F);
        chk("t3_lsb", sout_lsb, 32'h1);
        chk("t3_cnt", shift_cnt, 32'h4);
        chk("t3_done", frame_done, 32'h0);

        // en=0 blocks a LOAD; the next enabled edge performs it.
        drive(0, 3, 0, 0, 8'h55, 0);
        settle();
        chk("t4_hold_q", q, 32'h0F);
        chk("t4_hold_cnt", shift_cnt, 32'h4);
        drive(1, 3, 0, 0, 8'h55, 0);
        settle();
        chk("t4_q", q, 32'h55);
        chk("t4_cnt", shift_cnt, 32'h0);

        // Load in mid-frame restarts the count; mixed directions all count.
        for (int i = 0; i < 5; i++) drive(1, (i % 2) + 1, 1, 0, 0, 0);
        drive(1, 3, 0, 0, 8'h3C, 0);
        for (int i = 0; i < 7; i++) drive(1, (i % 2) + 1, i % 2, 1, 0, 0);
        settle();
        chk("t5_no_done", frame_done, 32'h0);
        chk("t5_cnt7", shift_cnt, 32'h7);
        drive(1, 1, 0, 0, 0, 0);
        settle();
        chk("t5_done", frame_done, 32'h1);

`ifdef USR_ROTATE_EN
        drive(1, 3, 0, 0, 8'h81, 0);
        drive(1, 1, 0, 0, 0, 1);
        settle();
        chk("t6_rol", q, 32'h03);
        drive(1, 2, 1, 1, 0, 1);
        drive(1, 2, 1, 1, 0, 1);
        settle();
        chk("t6_ror", q, 32'hC0);
        for (int i = 0; i < W; i++) drive(1, 1, 1, 1, 0, 1);
        settle();
        chk("t6_full_rot", q, 32'hC0);
`endif

        // Randomised traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if (i % 130 == 129) begin
                async_reset();
            end else begin
                drive(($urandom_range(0, 7) != 0), $urandom_range(0, 3),
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 255), 1'($urandom_range(0, 1)));
            end
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
